// File: rtl/core_dispatch_scheduler_pkg.sv
// mspu_sched_pkg -- shared types for the core dispatch scheduler.
//   sched_state_t : offer FSM state encoding (SEARCH / OFFER / HOLD)
//   idx_w()       : index width needed to address n cores
package mspu_sched_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        OFFER  = 2'd1,
        HOLD   = 2'd2
    } sched_state_t;

    // Width of a core index; never below 1 so a 2-core build still has a bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/core_dispatch_scheduler_if.sv
// core_dispatch_scheduler_if -- offer/dispatch handshake between the
// scheduler and the stream parser.
//   core_valid / core_id         : scheduler offers an idle, enabled core
//   dispatch_valid / dispatch_core : parser starts sending to a core
// Modports: slave = scheduler side, master = parser side.
interface core_dispatch_scheduler_if #(
    parameter int CORES = 4
) ();
    localparam int W = mspu_sched_pkg::idx_w(CORES);

    logic         dispatch_valid;
    logic [W-1:0] dispatch_core;
    logic         core_valid;
    logic [W-1:0] core_id;

    modport slave (
        input  dispatch_valid,
        input  dispatch_core,
        output core_valid,
        output core_id
    );

    modport master (
        output dispatch_valid,
        output dispatch_core,
        input  core_valid,
        input  core_id
    );
endinterface

// File: rtl/core_dispatch_scheduler_rr_pick.sv
// rr_pick -- combinational round-robin picker.
//   req   : request vector (N bits, N a power of two)
//   ptr   : starting index of the scan
//   found : any request bit set
//   index : first set bit at or above ptr, wrapping to 0
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] index
);
    logic [W-1:0] probe;

    // Scan offsets from the far end down so the nearest hit is written last.
    // ptr + k wraps in W bits, which is the modulo-N step since N = 2**W.
    always_comb begin
        found = 1'b0;
        index = '0;
        probe = '0;
        for (int k = N - 1; k >= 0; k--) begin
            probe = ptr + W'(k);
            if (req[probe]) begin
                found = 1'b1;
                index = probe;
            end
        end
    end
endmodule

// File: rtl/core_dispatch_scheduler.sv
// core_dispatch_scheduler -- offers idle, enabled cores to the stream parser
// in round-robin order and tracks which cores hold a job.
//   clk, reset_n    : rising-edge clock, synchronous active-low reset
//   disp (slave)    : core_valid/core_id offer, dispatch_valid/dispatch_core
//   core_enable     : per-core enable, 1 = core may be offered
//   core_done       : per-core one-cycle completion pulse
//   busy_mask       : 1 = core holds a job
//   busy_count      : popcount of busy_mask
//   dispatch_count  : accepted dispatches, free-running 32-bit wrap
//   sched_error     : one-cycle pulse on dispatch-to-busy or done-on-idle
module core_dispatch_scheduler
    import mspu_sched_pkg::*;
#(
    parameter int CORES = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    core_dispatch_scheduler_if.slave   disp,
    input  logic [CORES-1:0]           core_enable,
    input  logic [CORES-1:0]           core_done,
    output logic [CORES-1:0]           busy_mask,
    output logic [idx_w(CORES):0]      busy_count,
    output logic [31:0]                dispatch_count,
    output logic                       sched_error
);
    localparam int W = idx_w(CORES);

    sched_state_t   state;
    logic [W-1:0]   rr_ptr;

    logic [CORES-1:0] cand;
    logic [CORES-1:0] disp_onehot;
    logic [CORES-1:0] busy_nxt;
    logic             pick_found;
    logic [W-1:0]     pick_idx;
    logic             err_nxt;
    logic             offer_hit;

    function automatic logic [W:0] popcnt(input logic [CORES-1:0] v);
        logic [W:0] c;
        c = '0;
        for (int i = 0; i < CORES; i++) c = c + {{W{1'b0}}, v[i]};
        return c;
    endfunction

    assign cand = core_enable & ~busy_mask;

    rr_pick #(.N(CORES), .W(W)) u_pick (
        .req   (cand),
        .ptr   (rr_ptr),
        .found (pick_found),
        .index (pick_idx)
    );

    // Dispatch sets and done clears are both applied; OR-ing the set after
    // the clear makes set win when the same core sees both in one cycle.
    always_comb begin
        disp_onehot = '0;
        if (disp.dispatch_valid) disp_onehot[disp.dispatch_core] = 1'b1;
        busy_nxt  = (busy_mask & ~core_done) | disp_onehot;
        err_nxt   = (disp.dispatch_valid && busy_mask[disp.dispatch_core])
                  || |(core_done & ~busy_mask);
        offer_hit = disp.dispatch_valid && (disp.dispatch_core == disp.core_id);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= SEARCH;
            rr_ptr          <= '0;
            disp.core_valid <= 1'b0;
            disp.core_id    <= '0;
            busy_mask       <= '0;
            busy_count      <= '0;
            dispatch_count  <= '0;
            sched_error     <= 1'b0;
        end else begin
            busy_mask   <= busy_nxt;
            busy_count  <= popcnt(busy_nxt);
            sched_error <= err_nxt;
            if (disp.dispatch_valid) dispatch_count <= dispatch_count + 32'd1;

            case (state)
                SEARCH: begin
                    if (pick_found) begin
                        state           <= OFFER;
                        disp.core_id    <= pick_idx;
                        disp.core_valid <= 1'b1;
                    end
                end
                OFFER: begin
                    if (offer_hit) begin
                        state           <= HOLD;
                        disp.core_valid <= 1'b0;
                        rr_ptr          <= disp.core_id + W'(1);
                    end else if (!core_enable[disp.core_id]) begin
                        // Offered core was withdrawn; rescan next cycle.
                        state           <= SEARCH;
                        disp.core_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    // One dead cycle so the new busy bit is visible to SEARCH.
                    state <= SEARCH;
                end
                default: begin
                    state           <= SEARCH;
                    disp.core_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_core_dispatch_scheduler.sv
module tb_core_dispatch_scheduler;
    localparam int CORES = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  core_enable;
    logic [3:0]  core_done;
    logic [3:0]  busy_mask;
    logic [2:0]  busy_count;
    logic [31:0] dispatch_count;
    logic        sched_error;

    int total = 0;
    int bad   = 0;

    core_dispatch_scheduler_if #(.CORES(CORES)) disp ();

    core_dispatch_scheduler #(.CORES(CORES)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .disp           (disp),
        .core_enable    (core_enable),
        .core_done      (core_done),
        .busy_mask      (busy_mask),
        .busy_count     (busy_count),
        .dispatch_count (dispatch_count),
        .sched_error    (sched_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] en;
        logic [3:0] done;
        logic       dv;
        logic [1:0] dc;
        logic       cv;
        logic [1:0] id;
        logic [3:0] busy;
        logic       err;
    } vec_t;

    vec_t tbl [32];

    function automatic vec_t mk(input logic [3:0] en, input logic [3:0] done,
                                input logic dv, input logic [1:0] dc,
                                input logic cv, input logic [1:0] id,
                                input logic [3:0] busy, input logic err);
        vec_t v;
        v.en = en; v.done = done; v.dv = dv; v.dc = dc;
        v.cv = cv; v.id = id; v.busy = busy; v.err = err;
        return v;
    endfunction

    function automatic logic [2:0] pop4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // en  done dv dc   cv id busy err
        tbl[0]  = mk(4'hF, 4'h0, 0, 0,  1, 0, 4'h0, 0); // first offer core 0
        tbl[1]  = mk(4'hF, 4'h0, 1, 0,  0, 0, 4'h1, 0); // take core 0
        tbl[2]  = mk(4'hF, 4'h0, 0, 0,  0, 0, 4'h1, 0); // HOLD
        tbl[3]  = mk(4'hF, 4'h0, 0, 0,  1, 1, 4'h1, 0); // next offer core 1
        tbl[4]  = mk(4'hF, 4'h0, 1, 1,  0, 0, 4'h3, 0);
        tbl[5]  = mk(4'hF, 4'h0, 0, 0,  0, 0, 4'h3, 0);
        tbl[6]  = mk(4'hF, 4'h0, 0, 0,  1, 2, 4'h3, 0);
        tbl[7]  = mk(4'hF, 4'h0, 1, 2,  0, 0, 4'h7, 0);
        tbl[8]  = mk(4'hF, 4'h0, 0, 0,  0, 0, 4'h7, 0);
        tbl[9]  = mk(4'hF, 4'h0, 0, 0,  1, 3, 4'h7, 0);
        tbl[10] = mk(4'hF, 4'h0, 1, 3,  0, 0, 4'hF, 0); // all busy
        tbl[11] = mk(4'hF, 4'h0, 0, 0,  0, 0, 4'hF, 0);
        tbl[12] = mk(4'hF, 4'h0, 0, 0,  0, 0, 4'hF, 0); // nothing to offer
        tbl[13] = mk(4'hF, 4'h4, 0, 0,  0, 0, 4'hB, 0); // free core 2
        tbl[14] = mk(4'hF, 4'h0, 0, 0,  1, 2, 4'hB, 0); // offer core 2
        tbl[15] = mk(4'hA, 4'h0, 0, 0,  0, 0, 4'hB, 0); // enable[2] drops
        tbl[16] = mk(4'hA, 4'hA, 0, 0,  0, 0, 4'h1, 0); // free 1 and 3
        tbl[17] = mk(4'hA, 4'h0, 0, 0,  1, 1, 4'h1, 0);
        tbl[18] = mk(4'hA, 4'h0, 1, 1,  0, 0, 4'h3, 0);
        tbl[19] = mk(4'hA, 4'h0, 0, 0,  0, 0, 4'h3, 0);
        tbl[20] = mk(4'hA, 4'h0, 0, 0,  1, 3, 4'h3, 0);
        tbl[21] = mk(4'hA, 4'h0, 1, 3,  0, 0, 4'hB, 0);
        tbl[22] = mk(4'hA, 4'h2, 0, 0,  0, 0, 4'h9, 0); // done during HOLD
        tbl[23] = mk(4'hA, 4'h0, 0, 0,  1, 1, 4'h9, 0); // 1,3,1
        tbl[24] = mk(4'h8, 4'h8, 0, 0,  0, 0, 4'h1, 0); // drop enable[1]
        tbl[25] = mk(4'h8, 4'h0, 0, 0,  1, 3, 4'h1, 0); // offer core 3
        tbl[26] = mk(4'h8, 4'h0, 1, 1,  1, 3, 4'h3, 0); // off-offer dispatch
        tbl[27] = mk(4'h8, 4'h1, 1, 2,  1, 3, 4'h6, 0); // dispatch 2 + done 0
        tbl[28] = mk(4'h8, 4'h0, 1, 1,  1, 3, 4'h6, 1); // dispatch to busy
        tbl[29] = mk(4'h8, 4'h0, 0, 0,  1, 3, 4'h6, 0); // pulse is one cycle
        tbl[30] = mk(4'h8, 4'h8, 0, 0,  1, 3, 4'h6, 1); // done on idle core
        tbl[31] = mk(4'h8, 4'h0, 0, 0,  1, 3, 4'h6, 0);

        reset_n = 1'b0;
        core_enable = '0;
        core_done = '0;
        disp.dispatch_valid = 1'b0;
        disp.dispatch_core = '0;
        tick();
        tick();
        chk("rst_cv",    32'(disp.core_valid), 0);
        chk("rst_id",    32'(disp.core_id), 0);
        chk("rst_busy",  32'(busy_mask), 0);
        chk("rst_bcnt",  32'(busy_count), 0);
        chk("rst_dcnt",  dispatch_count, 0);
        chk("rst_err",   32'(sched_error), 0);

        reset_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            core_enable = tbl[i].en;
            core_done = tbl[i].done;
            disp.dispatch_valid = tbl[i].dv;
            disp.dispatch_core = tbl[i].dc;
            tick();
            chk($sformatf("v%0d_cv", i),   32'(disp.core_valid), 32'(tbl[i].cv));
            if (tbl[i].cv)
                chk($sformatf("v%0d_id", i), 32'(disp.core_id), 32'(tbl[i].id));
            chk($sformatf("v%0d_busy", i), 32'(busy_mask), 32'(tbl[i].busy));
            chk($sformatf("v%0d_bcnt", i), 32'(busy_count), 32'(pop4(tbl[i].busy)));
            chk($sformatf("v%0d_err", i),  32'(sched_error), 32'(tbl[i].err));
        end
        chk("dcnt_after_table", dispatch_count, 9);

        // Counter wrap: preload all-ones, then one more dispatch.
        core_done = '0;
        disp.dispatch_valid = 1'b0;
        force dut.dispatch_count = 32'hFFFF_FFFF;
        #1;
        release dut.dispatch_count;
        disp.dispatch_valid = 1'b1;
        disp.dispatch_core = 2'd0;
        tick();
        disp.dispatch_valid = 1'b0;
        chk("wrap_dcnt", dispatch_count, 0);
        chk("wrap_busy", 32'(busy_mask), 32'h7);
        chk("wrap_err",  32'(sched_error), 0);
        chk("wrap_cv",   32'(disp.core_valid), 1);

        // Reset while an offer is outstanding.
        reset_n = 1'b0;
        tick();
        chk("midrst_cv",   32'(disp.core_valid), 0);
        chk("midrst_busy", 32'(busy_mask), 0);
        chk("midrst_bcnt", 32'(busy_count), 0);
        chk("midrst_dcnt", dispatch_count, 0);

        // Jobs forgotten and rr pointer back at 0.
        reset_n = 1'b1;
        core_enable = 4'hF;
        tick();
        chk("postrst_cv", 32'(disp.core_valid), 1);
        chk("postrst_id", 32'(disp.core_id), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
